// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module   : mux_scan_pkg
// Brief    : Shared types and constants for the 16-channel mux scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

   localparam int NCH   = 16;
   localparam int SEL_W = 4;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      VALID  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module   : mux_scan_sequencer
// Brief    : Steps a 16:1 select tree through all channels with a settle delay,
//            captures a 16-bit snapshot and offers it on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_out,
   output logic [NCH-1:0]   data,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [SEL_W-1:0] r_sel;
   logic [NCH-1:0]   r_buf;
   logic [NCH-1:0]   r_data;
   logic             w_settled;
   logic             w_last;

   assign w_settled = (r_cnt == CNT_W'(SETTLE));
   assign w_last    = (r_sel == SEL_W'(NCH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start)      w_next = WAIT;
         WAIT:    if (w_settled)  w_next = SAMPLE;
         SAMPLE:  w_next = w_last ? VALID : WAIT;
         VALID:   if (data_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // The last channel bypasses scan_buf so the snapshot lands on the same edge it is sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_sel  <= '0;
         r_buf  <= '0;
         r_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               r_sel <= '0;
               r_buf <= '0;
            end
            WAIT: begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
            SAMPLE: begin
               r_buf[r_sel] <= mux_out;
               r_cnt        <= '0;
               if (w_last) begin
                  r_data <= {mux_out, r_buf[NCH-2:0]};
               end else begin
                  r_sel <= r_sel + SEL_W'(1);
               end
            end
            VALID: begin
               if (data_ready) begin
                  r_sel <= '0;
               end
            end
            default: begin
               r_cnt <= '0;
               r_sel <= '0;
            end
         endcase
      end
   end

   assign mux_sel    = r_sel;
   assign data       = r_data;
   assign data_valid = (r_state == VALID);
   assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequencer upstream of the 16:1 select tree (`mux16to1_using_4to1`). On a start request it drives the tree's 4-bit select through channels 0..15 and waits a programmable settle time per channel. It samples the tree's 1-bit output for each channel, assembles a 16-bit snapshot, and presents it downstream on a valid/ready handshake.

## Interface
- `SETTLE`, default 1: settle cycles per channel before sampling; legal range 0..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: scan request; sampled only in IDLE.
- `mux_sel` out 4: select to the 16:1 tree; registered.
- `mux_out` in 1: tree output, combinational from `mux_sel`.
- `data` out 16: last completed snapshot; `data[k]` is the `mux_out` value sampled while `mux_sel==k`.
- `data_valid` out 1: snapshot available.
- `data_ready` in 1: downstream accepts the snapshot.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, WAIT, SAMPLE, VALID.
- IDLE:
  - `start=1` → WAIT.
  - `mux_sel` is set to 0, the settle counter to 0, and the scan buffer cleared.
- WAIT:
  - The settle counter increments each cycle.
  - When the count reaches `SETTLE`, go to SAMPLE.
  - With `SETTLE=0`, WAIT lasts one cycle and goes straight to SAMPLE on the next edge.
- SAMPLE:
  - On the exit edge, `scan_buf[mux_sel] <= mux_out`.
  - If `mux_sel==15`: `data <= {mux_out, scan_buf[14:0]}`, go to VALID, `mux_sel` holds at 15.
  - Otherwise: `mux_sel` increments, the counter is cleared, go to WAIT.
- VALID:
  - `data_valid=1`; `data` is held stable.
  - `data_ready=1` → IDLE. `data_valid` drops and `mux_sel` returns to 0 on that edge.
- `start` outside IDLE is ignored, not queued. This includes `start` in the same cycle as a VALID→IDLE handshake.
- `data` changes only on the SAMPLE(15)→VALID edge. It keeps its value after the handshake until the next scan completes.
- `mux_sel` never wraps 15→0 inside a scan. It returns to 0 only via VALID→IDLE or reset.
- `mux_out` is sampled only on SAMPLE exit edges; its value in any other cycle has no effect.

## Timing
- Reset values: `mux_sel=0`, `data=16'h0000`, `data_valid=0`, `busy=0`, state IDLE, `scan_buf=0`, counter 0.
- Channel period P = `SETTLE`+2 cycles: `SETTLE`+1 cycles in WAIT plus 1 in SAMPLE.
- Let edge 0 be the IDLE edge on which `start` is seen high.
  - `busy` rises after edge 0.
  - Channel k is sampled on edge (k+1)·P.
  - `data_valid` rises after edge 16·P. With `SETTLE=1`, that is after edge 48.
- `mux_sel==k` holds for exactly P cycles before its sample edge. This is the settle guarantee to the combinational tree.
- If `data_ready=1` in the first VALID cycle, `data_valid` is high for exactly one cycle.
- Minimum start-to-start interval: 16·P+2 edges.
- `rst_n` assertion at any time:
  - Immediate asynchronous return to the reset values.
  - A partial scan is discarded and not presented.
  - `data` from earlier scans is cleared.
- Deassertion is synchronised externally; the first active edge after release is treated as IDLE.

## Structure
- Package `mux_scan_pkg`:
  - state enum (IDLE, WAIT, SAMPLE, VALID)
  - `NCH=16`
  - `SEL_W=4`
  - `CNT_W=4`
- No sub-module is required; the settle counter is inline.
- The testbench instantiates this block together with the existing 16:1 tree as its load.

## Test plan
- Basic scan:
  - Stimulus: `SETTLE=1`, tree inputs 16'hA5C3, single-cycle `start`, `data_ready` tied 1.
  - Response: `data==16'hA5C3`; `data_valid` high for one cycle after edge 48; `mux_sel` sequence 0,0,0,1,1,1,…,15.
- Back-pressure:
  - Stimulus: hold `data_ready=0` for 20 cycles after `data_valid` rises; change tree inputs to 16'hFFFF meanwhile.
  - Response: `data` stays 16'hA5C3 and `data_valid` stays high; release `ready` → IDLE next edge, `mux_sel=0`.
- Ignored start:
  - Stimulus: pulse `start` at cycles 5, 20 and in the handshake cycle.
  - Response: exactly one scan; `busy` falls after the handshake and stays 0.
- `SETTLE=0`, walking one:
  - Stimulus: tree inputs 16'h0001 <<k for k=0..15, one scan each.
  - Response: `data==1<<k` each time; `data_valid` after edge 32.
- Reset mid-scan:
  - Stimulus: assert `rst_n` low during channel 7 of a scan, release, rescan with inputs 16'h1234.
  - Response: outputs at reset values immediately; no `data_valid` from the aborted scan; next result 16'h1234.
- Input glitch outside SAMPLE:
  - Stimulus: toggle the tree input of the current channel during WAIT cycles, stable in SAMPLE.
  - Response: only the SAMPLE-cycle value is captured.
